// File: rtl/store_rmw_packer.sv
// MEM-stage store packer: narrows register data to word/half/byte and writes it
// to a word-wide memory without byte enables, using read-modify-write for sub-word stores.
module store_rmw_packer #(
   parameter int NBITS      = 32,
   parameter int ADDR_NBITS = 10
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [ADDR_NBITS-1:0] i_addr,
   input  logic [NBITS-1:0]      i_data,
   input  logic [1:0]            i_StoreMode,
   output logic [ADDR_NBITS-3:0] o_mem_addr,
   output logic                  o_mem_re,
   input  logic [NBITS-1:0]      i_mem_rdata,
   output logic                  o_mem_we,
   output logic [NBITS-1:0]      o_mem_wdata,
   output logic                  o_done,
   output logic                  o_misaligned
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_ERR
   } state_t;

   localparam logic [1:0] MODE_SW = 2'b00;
   localparam logic [1:0] MODE_SH = 2'b01;
   localparam logic [1:0] MODE_SB = 2'b10;

   state_t                  state, state_nxt;
   logic [1:0]              lane_q, lane_nxt;
   logic                    is_byte_q, is_byte_nxt;
   logic [15:0]             data_q, data_nxt;
   logic [ADDR_NBITS-3:0]   addr_nxt;
   logic [NBITS-1:0]        wdata_nxt;
   logic                    re_nxt, we_nxt, done_nxt, mis_nxt;
   logic                    illegal;
   logic [NBITS-1:0]        merged;

   assign o_ready = (state == S_IDLE);

   assign illegal = (i_StoreMode == 2'b11)
                  || (i_StoreMode == MODE_SH && i_addr[0])
                  || (i_StoreMode == MODE_SW && i_addr[1:0] != 2'b00);

   // Little-endian lane insert of the captured low data bits into the old word.
   always_comb begin
      merged = i_mem_rdata;
      if (is_byte_q)
         merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
      else
         merged[{lane_q[1], 4'b0000} +: 16] = data_q;
   end

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      lane_nxt    = lane_q;
      is_byte_nxt = is_byte_q;
      data_nxt    = data_q;
      addr_nxt    = o_mem_addr;
      wdata_nxt   = o_mem_wdata;
      re_nxt      = 1'b0;
      we_nxt      = 1'b0;
      done_nxt    = 1'b0;
      mis_nxt     = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_valid) begin
               lane_nxt    = i_addr[1:0];
               is_byte_nxt = (i_StoreMode == MODE_SB);
               data_nxt    = i_data[15:0];
               addr_nxt    = i_addr[ADDR_NBITS-1:2];
               if (illegal) begin
                  state_nxt = S_ERR;
                  mis_nxt   = 1'b1;
               end else if (i_StoreMode == MODE_SW) begin
                  state_nxt = S_WRITE;
                  wdata_nxt = i_data;
                  we_nxt    = 1'b1;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = S_READ;
                  re_nxt    = 1'b1;
               end
            end
         end
         S_READ:  state_nxt = S_WAIT;
         S_WAIT: begin
            state_nxt = S_WRITE;
            wdata_nxt = merged;
            we_nxt    = 1'b1;
            done_nxt  = 1'b1;
         end
         S_WRITE: state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state        <= S_IDLE;
         lane_q       <= '0;
         is_byte_q    <= 1'b0;
         data_q       <= '0;
         o_mem_addr   <= '0;
         o_mem_wdata  <= '0;
         o_mem_re     <= 1'b0;
         o_mem_we     <= 1'b0;
         o_done       <= 1'b0;
         o_misaligned <= 1'b0;
      end else begin
         state        <= state_nxt;
         lane_q       <= lane_nxt;
         is_byte_q    <= is_byte_nxt;
         data_q       <= data_nxt;
         o_mem_addr   <= addr_nxt;
         o_mem_wdata  <= wdata_nxt;
         o_mem_re     <= re_nxt;
         o_mem_we     <= we_nxt;
         o_done       <= done_nxt;
         o_misaligned <= mis_nxt;
      end
   end

endmodule

// File: tb/tb_store_rmw_packer.sv
// Directed bench for store_rmw_packer: a vector table of single stores plus
// hand-written reset-abort and back-to-back sequences.
module tb_store_rmw_packer;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_valid;
   logic        o_ready;
   logic [9:0]  i_addr;
   logic [31:0] i_data;
   logic [1:0]  i_StoreMode;
   logic [7:0]  o_mem_addr;
   logic        o_mem_re;
   logic [31:0] i_mem_rdata;
   logic        o_mem_we;
   logic [31:0] o_mem_wdata;
   logic        o_done;
   logic        o_misaligned;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] JUNK = 32'h5A5A_A5A5;

   store_rmw_packer #(.NBITS(32), .ADDR_NBITS(10)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_addr       (i_addr),
      .i_data       (i_data),
      .i_StoreMode  (i_StoreMode),
      .o_mem_addr   (o_mem_addr),
      .o_mem_re     (o_mem_re),
      .i_mem_rdata  (i_mem_rdata),
      .o_mem_we     (o_mem_we),
      .o_mem_wdata  (o_mem_wdata),
      .o_done       (o_done),
      .o_misaligned (o_misaligned)
   );

   always #5 i_clk = ~i_clk;

   typedef enum logic [1:0] {K_WORD, K_RMW, K_ERR} kind_t;

   typedef struct {
      logic [1:0]  mode;
      logic [9:0]  addr;
      logic [31:0] data;
      logic [31:0] rdata;
      kind_t       kind;
      logic [7:0]  exp_addr;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one store and watch seven cycles after acceptance; memory returns
   // the vector's word only in the cycle after o_mem_re, junk otherwise.
   task automatic run_vec(input int idx, input vec_t v);
      int re_n = 0, we_n = 0, done_n = 0, mis_n = 0, both_n = 0;
      int re_c = 0, we_c = 0, mis_c = 0, ready_c = 0;
      logic [7:0]  re_a = '0, we_a = '0;
      logic [31:0] wd = '0;
      logic        prev_re = 1'b0;
      int exp_we_c, exp_ready_c;
      @(negedge i_clk);
      check($sformatf("v%0d_ready_before", idx), 32'(o_ready), 32'd1);
      i_valid     = 1'b1;
      i_addr      = v.addr;
      i_data      = v.data;
      i_StoreMode = v.mode;
      i_mem_rdata = JUNK;
      @(posedge i_clk);
      #1;
      i_valid     = 1'b0;
      i_addr      = 10'h3FF;
      i_data      = 32'hFFFF_FFFF;
      i_StoreMode = 2'b11;
      for (int c = 1; c <= 7; c++) begin
         @(negedge i_clk);
         i_mem_rdata = prev_re ? v.rdata : JUNK;
         prev_re = o_mem_re;
         if (o_mem_re) begin re_n++; if (re_c == 0) begin re_c = c; re_a = o_mem_addr; end end
         if (o_mem_we) begin we_n++; if (we_c == 0) begin we_c = c; we_a = o_mem_addr; wd = o_mem_wdata; end end
         if (o_mem_re && o_mem_we) both_n++;
         if (o_done) done_n++;
         if (o_misaligned) begin mis_n++; if (mis_c == 0) mis_c = c; end
         if (o_ready && ready_c == 0) ready_c = c;
      end
      exp_we_c    = (v.kind == K_WORD) ? 1 : (v.kind == K_RMW) ? 3 : 0;
      exp_ready_c = (v.kind == K_RMW) ? 4 : 2;
      check($sformatf("v%0d_we_cycle", idx), 32'(we_c), 32'(exp_we_c));
      check($sformatf("v%0d_we_count", idx), 32'(we_n), (v.kind == K_ERR) ? 32'd0 : 32'd1);
      check($sformatf("v%0d_done_count", idx), 32'(done_n), (v.kind == K_ERR) ? 32'd0 : 32'd1);
      check($sformatf("v%0d_re_count", idx), 32'(re_n), (v.kind == K_RMW) ? 32'd1 : 32'd0);
      check($sformatf("v%0d_mis_count", idx), 32'(mis_n), (v.kind == K_ERR) ? 32'd1 : 32'd0);
      check($sformatf("v%0d_ready_cycle", idx), 32'(ready_c), 32'(exp_ready_c));
      check($sformatf("v%0d_re_we_overlap", idx), 32'(both_n), 32'd0);
      if (v.kind == K_ERR) begin
         check($sformatf("v%0d_mis_cycle", idx), 32'(mis_c), 32'd1);
      end else begin
         check($sformatf("v%0d_wdata", idx), wd, v.exp_wdata);
         check($sformatf("v%0d_we_addr", idx), 32'(we_a), 32'(v.exp_addr));
      end
      if (v.kind == K_RMW) begin
         check($sformatf("v%0d_re_cycle", idx), 32'(re_c), 32'd1);
         check($sformatf("v%0d_re_addr", idx), 32'(re_a), 32'(v.exp_addr));
      end
   endtask

   initial begin
      int re_n, we_n, done_n, we1_c, we2_c;
      logic [31:0] wd1, wd2;
      logic prev_re;

      vecs[0]  = '{2'b00, 10'h010, 32'hDEAD_BEEF, 32'h0000_0000, K_WORD, 8'h04, 32'hDEAD_BEEF};
      vecs[1]  = '{2'b10, 10'h013, 32'h1234_56AA, 32'h1122_3344, K_RMW,  8'h04, 32'hAA22_3344};
      vecs[2]  = '{2'b01, 10'h006, 32'h1234_ABCD, 32'hFFFF_FFFF, K_RMW,  8'h01, 32'hABCD_FFFF};
      vecs[3]  = '{2'b01, 10'h004, 32'h1234_ABCD, 32'hFFFF_FFFF, K_RMW,  8'h01, 32'hFFFF_ABCD};
      vecs[4]  = '{2'b10, 10'h000, 32'hFFFF_FF5C, 32'h1122_3344, K_RMW,  8'h00, 32'h1122_335C};
      vecs[5]  = '{2'b10, 10'h3FD, 32'h0000_0077, 32'hA0B0_C0D0, K_RMW,  8'hFF, 32'hA0B0_77D0};
      vecs[6]  = '{2'b10, 10'h022, 32'h0000_0099, 32'h0000_0000, K_RMW,  8'h08, 32'h0099_0000};
      vecs[7]  = '{2'b01, 10'h005, 32'h1234_ABCD, 32'h0000_0000, K_ERR,  8'h00, 32'h0000_0000};
      vecs[8]  = '{2'b00, 10'h012, 32'hDEAD_BEEF, 32'h0000_0000, K_ERR,  8'h00, 32'h0000_0000};
      vecs[9]  = '{2'b11, 10'h000, 32'h0000_0001, 32'h0000_0000, K_ERR,  8'h00, 32'h0000_0000};
      vecs[10] = '{2'b00, 10'h3FC, 32'h0BAD_F00D, 32'h0000_0000, K_WORD, 8'hFF, 32'h0BAD_F00D};

      i_reset     = 1'b0;
      i_valid     = 1'b0;
      i_addr      = '0;
      i_data      = '0;
      i_StoreMode = 2'b00;
      i_mem_rdata = JUNK;
      repeat (2) @(negedge i_clk);
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_outputs", {28'd0, o_mem_re, o_mem_we, o_done, o_misaligned}, 32'd0);
      check("rst_addr", 32'(o_mem_addr), 32'd0);
      check("rst_wdata", o_mem_wdata, 32'd0);
      i_reset = 1'b1;

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Reset asserted while the SB read data is being waited on.
      @(negedge i_clk);
      i_valid     = 1'b1;
      i_addr      = 10'h013;
      i_data      = 32'h1234_56AA;
      i_StoreMode = 2'b10;
      @(posedge i_clk);
      #1 i_valid = 1'b0;
      @(negedge i_clk);
      check("abort_re_in_read", 32'(o_mem_re), 32'd1);
      i_mem_rdata = 32'h1122_3344;
      @(negedge i_clk);
      i_reset = 1'b0;
      #1;
      check("abort_outputs", {28'd0, o_mem_re, o_mem_we, o_done, o_misaligned}, 32'd0);
      check("abort_addr", 32'(o_mem_addr), 32'd0);
      check("abort_wdata", o_mem_wdata, 32'd0);
      check("abort_ready", 32'(o_ready), 32'd1);
      we_n = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge i_clk);
         if (o_mem_we || o_done) we_n++;
      end
      check("abort_no_write", 32'(we_n), 32'd0);
      i_reset = 1'b1;
      i_mem_rdata = JUNK;
      run_vec(100, vecs[0]);

      // Back-to-back: valid held high, SB followed by SW.
      @(negedge i_clk);
      i_valid     = 1'b1;
      i_addr      = 10'h013;
      i_data      = 32'h1234_56AA;
      i_StoreMode = 2'b10;
      @(posedge i_clk);
      #1;
      i_addr      = 10'h010;
      i_data      = 32'hDEAD_BEEF;
      i_StoreMode = 2'b00;
      re_n = 0; we_n = 0; done_n = 0; we1_c = 0; we2_c = 0;
      wd1 = '0; wd2 = '0; prev_re = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge i_clk);
         i_mem_rdata = prev_re ? 32'h1122_3344 : JUNK;
         prev_re = o_mem_re;
         if (c == 4) check("b2b_ready_t4", 32'(o_ready), 32'd1);
         if (c == 5) i_valid = 1'b0;
         if (o_mem_re) re_n++;
         if (o_done) done_n++;
         if (o_mem_we) begin
            we_n++;
            if (we_n == 1) begin we1_c = c; wd1 = o_mem_wdata; end
            else begin we2_c = c; wd2 = o_mem_wdata; end
         end
      end
      check("b2b_re_count", 32'(re_n), 32'd1);
      check("b2b_we_count", 32'(we_n), 32'd2);
      check("b2b_done_count", 32'(done_n), 32'd2);
      check("b2b_sb_we_cycle", 32'(we1_c), 32'd3);
      check("b2b_sb_wdata", wd1, 32'hAA22_3344);
      check("b2b_sw_we_cycle", 32'(we2_c), 32'd5);
      check("b2b_sw_wdata", wd2, 32'hDEAD_BEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
